// File: rtl/ct_f_spsram_param_if.sv
// Bus bundle for the parametrised single-port SRAM wrapper.
// Carries the CEN/GWEN/WEN macro-style access signals, the read data and the init busy flag.
interface ct_f_spsram_param_if #(
    parameter int WIDTH  = 59,
    parameter int ADDR_W = 10
);
    logic [ADDR_W-1:0] A;
    logic              CEN;
    logic              GWEN;
    logic [WIDTH-1:0]  WEN;
    logic [WIDTH-1:0]  D;
    logic [WIDTH-1:0]  Q;
    logic              BUSY;

    modport master (output A, CEN, GWEN, WEN, D, input Q, BUSY);
    modport slave  (input A, CEN, GWEN, WEN, D, output Q, BUSY);
endinterface

// File: rtl/ct_f_spsram_param.sv
// Parametrised FPGA single-port SRAM: per-slice write-first RAMs plus a post-reset clear sweep.
// Define CT_F_SRAM_OREG_EN to add an output register stage (read latency 2).
module ct_f_spsram_param #(
    parameter int               WIDTH    = 59,
    parameter int               DEPTH    = 1024,
    parameter int               ADDR_W   = 10,
    parameter int               SLICE_W  = 29,
    parameter logic [WIDTH-1:0] INIT_VAL = {WIDTH{1'b0}}
) (
    input  logic                CLK,
    input  logic                RST_B,
    ct_f_spsram_param_if.slave  bus
);
    localparam int                NSLICE    = (WIDTH + SLICE_W - 1) / SLICE_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_DONE = 2'd1
    } state_t;

    state_t            state_r;
    logic [ADDR_W-1:0] init_addr_r;
    logic              busy_r;
    logic [ADDR_W-1:0] addr_hold_r;
    logic              q_vld_r;
    logic [ADDR_W-1:0] ram_addr_s;
    logic              acc_s;
    logic [WIDTH-1:0]  rdata_s;

    assign acc_s    = !busy_r && !bus.CEN;
    assign bus.BUSY = busy_r;

    // Init sweep sequencer: clears every word once after reset, then parks in DONE
    always_ff @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
            state_r     <= ST_INIT;
            init_addr_r <= {ADDR_W{1'b0}};
            busy_r      <= 1'b1;
        end else begin
            case (state_r)
                ST_INIT: begin
                    if (init_addr_r == LAST_ADDR) begin
                        state_r <= ST_DONE;
                        busy_r  <= 1'b0;
                    end else begin
                        init_addr_r <= init_addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_DONE: begin
                    state_r <= ST_DONE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r     <= ST_INIT;
                    init_addr_r <= {ADDR_W{1'b0}};
                    busy_r      <= 1'b1;
                end
            endcase
        end
    end

    // Address hold and output-valid flag, both updated only by accepted accesses
    always_ff @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
            addr_hold_r <= {ADDR_W{1'b0}};
            q_vld_r     <= 1'b0;
        end else if (acc_s) begin
            addr_hold_r <= bus.A;
            q_vld_r     <= 1'b1;
        end else begin
            addr_hold_r <= addr_hold_r;
            q_vld_r     <= q_vld_r;
        end
    end

    // RAM address: sweep counter during init, else live A or the held address
    always_comb begin
        ram_addr_s = addr_hold_r;
        if (busy_r) begin
            ram_addr_s = init_addr_r;
        end else if (!bus.CEN) begin
            ram_addr_s = bus.A;
        end else begin
            ram_addr_s = addr_hold_r;
        end
    end

    for (genvar s = 0; s < NSLICE; s++) begin : g_slice
        localparam int LO = s * SLICE_W;
        localparam int HI = ((s + 1) * SLICE_W > WIDTH) ? (WIDTH - 1) : ((s + 1) * SLICE_W - 1);
        localparam int SW = HI - LO + 1;

        logic [SW-1:0] mem_r [DEPTH];
        logic [SW-1:0] rd_r;
        logic          we_s;
        logic [SW-1:0] wd_s;

        // Slice write strobe: the mask is sampled at the slice MSB only
        always_comb begin
            we_s = 1'b0;
            wd_s = bus.D[HI:LO];
            if (busy_r) begin
                we_s = 1'b1;
                wd_s = INIT_VAL[HI:LO];
            end else begin
                we_s = !bus.CEN && !bus.GWEN && !bus.WEN[HI];
                wd_s = bus.D[HI:LO];
            end
        end

        // Write-first slice RAM: a written slice returns the new data on the same edge
        always_ff @(posedge CLK) begin
            if (we_s) begin
                mem_r[ram_addr_s] <= wd_s;
                rd_r              <= wd_s;
            end else begin
                rd_r <= mem_r[ram_addr_s];
            end
        end

        assign rdata_s[HI:LO] = rd_r;
    end

`ifdef CT_F_SRAM_OREG_EN
    logic             acc_d_r;
    logic [WIDTH-1:0] q_r;

    // Output register: captures RAM data only on the edge after an accepted access
    always_ff @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
            acc_d_r <= 1'b0;
            q_r     <= {WIDTH{1'b0}};
        end else begin
            acc_d_r <= acc_s;
            if (acc_d_r && q_vld_r) begin
                q_r <= rdata_s;
            end else begin
                q_r <= q_r;
            end
        end
    end

    assign bus.Q = q_r;
`else
    assign bus.Q = q_vld_r ? rdata_s : {WIDTH{1'b0}};
`endif
endmodule

// File: tb/tb_ct_f_spsram_param.sv
// Self-checking bench for ct_f_spsram_param: a 59-bit/3-slice instance and a 64-bit/4-slice instance.
module tb_ct_f_spsram_param;
    localparam int W     = 59;
    localparam int W2    = 64;
    localparam int AW    = 10;
    localparam int DEPTH = 1024;
`ifdef CT_F_SRAM_OREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam logic [W-1:0]  ONES  = {W{1'b1}};
    localparam logic [W-1:0]  ZERO  = {W{1'b0}};
    localparam logic [W2-1:0] IV2   = 64'hDEAD_BEEF_0123_4567;

    logic clk   = 1'b0;
    logic rst_b = 1'b0;
    always #5 clk = ~clk;

    ct_f_spsram_param_if #(.WIDTH(W),  .ADDR_W(AW)) bus1 ();
    ct_f_spsram_param_if #(.WIDTH(W2), .ADDR_W(AW)) bus2 ();

    ct_f_spsram_param #(.WIDTH(W), .DEPTH(DEPTH), .ADDR_W(AW), .SLICE_W(29)) u_dut1 (
        .CLK(clk), .RST_B(rst_b), .bus(bus1));
    ct_f_spsram_param #(.WIDTH(W2), .DEPTH(DEPTH), .ADDR_W(AW), .SLICE_W(16), .INIT_VAL(IV2)) u_dut2 (
        .CLK(clk), .RST_B(rst_b), .bus(bus2));

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    typedef struct { int due; logic [W-1:0] exp; string name; } sb_t;
    sb_t sbq[$];

    typedef struct {
        string         name;
        logic [AW-1:0] a;
        logic          gwen;
        logic [W-1:0]  wen;
        logic [W-1:0]  d;
        logic          chk;
        logic [W-1:0]  exp;
    } vec_t;
    vec_t vt[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drain();
        sb_t e;
        while (sbq.size() > 0 && sbq[0].due == cycle) begin
            e = sbq.pop_front();
            check(e.name, 64'(bus1.Q), 64'(e.exp));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cycle++;
        #1;
        drain();
    endtask

    task automatic access1(input string name, input logic [AW-1:0] a, input logic gwen,
                           input logic [W-1:0] wen, input logic [W-1:0] d,
                           input logic chk, input logic [W-1:0] exp);
        sb_t e;
        bus1.A = a; bus1.CEN = 1'b0; bus1.GWEN = gwen; bus1.WEN = wen; bus1.D = d;
        if (chk) begin
            e.due = cycle + LAT; e.exp = exp; e.name = name;
            sbq.push_back(e);
        end
        tick();
        bus1.CEN = 1'b1;
    endtask

    task automatic idle1(input int n);
        bus1.CEN = 1'b1;
        repeat (n) tick();
    endtask

    task automatic access2(input string name, input logic [AW-1:0] a, input logic gwen,
                           input logic [W2-1:0] wen, input logic [W2-1:0] d, input logic [W2-1:0] exp);
        bus2.A = a; bus2.CEN = 1'b0; bus2.GWEN = gwen; bus2.WEN = wen; bus2.D = d;
        tick();
        bus2.CEN = 1'b1;
        repeat (LAT - 1) tick();
        check(name, bus2.Q, exp);
    endtask

    // Counts edges with BUSY high while hammering both DUTs with writes that must be ignored
    task automatic count_init(input string nm, input logic [AW-1:0] ga);
        int   n    = 0;
        logic qbad = 1'b0;
        while (bus1.BUSY && n < 2000) begin
            bus1.A = ga; bus1.CEN = 1'b0; bus1.GWEN = 1'b0; bus1.WEN = ZERO; bus1.D = ONES;
            bus2.A = ga; bus2.CEN = 1'b0; bus2.GWEN = 1'b0; bus2.WEN = 64'h0; bus2.D = ~IV2;
            tick();
            n++;
            if (bus1.Q !== ZERO || bus2.Q !== 64'h0) qbad = 1'b1;
        end
        bus1.CEN = 1'b1; bus2.CEN = 1'b1;
        check({nm, "_busy_edges"}, 64'(n), 64'(DEPTH));
        check({nm, "_q_zero"}, 64'(qbad), 64'h0);
        check({nm, "_busy2"}, 64'(bus2.BUSY), 64'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W2-1:0] m2, d2, acc2;
        vt[0] = '{"wr5_full",   10'd5,    1'b0, ZERO, ONES,  1'b1, ONES};
        vt[1] = '{"rd5_full",   10'd5,    1'b1, ONES, ZERO,  1'b1, ONES};
        vt[2] = '{"wr5_part",   10'd5,    1'b0, {30'h3FFF_FFFF, 29'h0}, ZERO, 1'b1, 59'h7FF_FFFF_E000_0000};
        vt[3] = '{"rd5_part",   10'd5,    1'b1, ONES, ZERO,  1'b1, 59'h7FF_FFFF_E000_0000};
        vt[4] = '{"wr9",        10'd9,    1'b0, ZERO, 59'h123, 1'b1, 59'h123};
        vt[5] = '{"rd0_init",   10'd0,    1'b1, ONES, ONES,  1'b1, ZERO};
        vt[6] = '{"rd511_init", 10'd511,  1'b1, ONES, ONES,  1'b1, ZERO};
        vt[7] = '{"rd1023_init",10'd1023, 1'b1, ONES, ONES,  1'b1, ZERO};
        vt[8] = '{"rd7_ignored",10'd7,    1'b1, ONES, ONES,  1'b1, ZERO};
        vt[9] = '{"rd9",        10'd9,    1'b1, ONES, ZERO,  1'b1, 59'h123};

        bus1.A = '0; bus1.CEN = 1'b1; bus1.GWEN = 1'b1; bus1.WEN = ONES; bus1.D = ZERO;
        bus2.A = '0; bus2.CEN = 1'b1; bus2.GWEN = 1'b1; bus2.WEN = {W2{1'b1}}; bus2.D = 64'h0;

        rst_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy1", 64'(bus1.BUSY), 64'h1);
        check("rst_q1",    64'(bus1.Q),    64'h0);
        check("rst_busy2", 64'(bus2.BUSY), 64'h1);
        check("rst_q2",    bus2.Q,         64'h0);
        @(negedge clk) rst_b = 1'b1;
        count_init("init1", 10'd7);

        for (int i = 0; i < 10; i++)
            access1(vt[i].name, vt[i].a, vt[i].gwen, vt[i].wen, vt[i].d, vt[i].chk, vt[i].exp);
        idle1(LAT + 1);

        // CEN high with a wandering address must keep the last read data
        for (int i = 0; i < 10; i++) begin
            bus1.CEN = 1'b1; bus1.A = AW'($urandom); bus1.GWEN = 1'($urandom);
            bus1.WEN = W'({$urandom, $urandom}); bus1.D = W'({$urandom, $urandom});
            tick();
            check("hold_q", 64'(bus1.Q), 64'h123);
        end

        access1("wr9_top", 10'd9, 1'b0, {1'b0, 58'h3FF_FFFF_FFFF_FFFF}, ONES, 1'b1, 59'h400_0000_0000_0123);
        access1("rd9_top", 10'd9, 1'b1, ONES, ZERO, 1'b1, 59'h400_0000_0000_0123);
        access1("wr1000",  10'd1000, 1'b0, ZERO, 59'h5A5, 1'b1, 59'h5A5);
        access1("rd1000",  10'd1000, 1'b1, ONES, ZERO, 1'b1, 59'h5A5);
        idle1(LAT + 1);

        @(negedge clk) rst_b = 1'b0;
        #1;
        check("rst2_busy", 64'(bus1.BUSY), 64'h1);
        check("rst2_q",    64'(bus1.Q),    64'h0);
        @(negedge clk) rst_b = 1'b1;
        repeat (300) tick();
        check("mid_busy", 64'(bus1.BUSY), 64'h1);
        @(negedge clk) rst_b = 1'b0;
        @(negedge clk) rst_b = 1'b1;
        count_init("init2", 10'd5);
        access1("rd1000_clr", 10'd1000, 1'b1, ONES, ZERO, 1'b1, ZERO);
        access1("rd5_clr",    10'd5,    1'b1, ONES, ZERO, 1'b1, ZERO);
        access1("rd9_clr",    10'd9,    1'b1, ONES, ZERO, 1'b1, ZERO);
        idle1(LAT + 1);

        // 64-bit / 16-bit-slice instance: INIT_VAL sweep and isolated slice writes
        access2("d2_rd30_init", 10'd30, 1'b1, {W2{1'b1}}, 64'h0, IV2);
        access2("d2_rd5_init",  10'd5,  1'b1, {W2{1'b1}}, 64'h0, IV2);
        acc2 = 64'h0123_4567_89AB_CDEF;
        access2("d2_wr20_full", 10'd20, 1'b0, 64'h0, acc2, acc2);
        for (int s = 0; s < 4; s++) begin
            m2   = 64'hFFFF << (16 * s);
            d2   = {$urandom, $urandom};
            acc2 = (acc2 & ~m2) | (d2 & m2);
            access2($sformatf("d2_wr_slice%0d", s), 10'd20, 1'b0, ~m2, d2, acc2);
            access2($sformatf("d2_rd_slice%0d", s), 10'd20, 1'b1, {W2{1'b1}}, ~d2, acc2);
        end
        idle1(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
